// File: rtl/pipe_control_pkg.sv
// pipe_control_pkg: shared definitions for the pipe_control slice.
//   - opcode values understood by the decoder
//   - ALU_Select operation codes
//   - PCControl encodings (STALL, INC, CONDLOAD)
//   - ctrl_t: the datapath control bundle produced by ctrl_decode
package pipe_control_pkg;

    // Opcodes are kept 32 bits wide so the decoder can compare against a
    // zero-extended OpCode whatever the configured opcode width is.
    localparam logic [31:0] OP_ADD  = 32'd0;
    localparam logic [31:0] OP_SUB  = 32'd1;
    localparam logic [31:0] OP_SLT  = 32'd2;
    localparam logic [31:0] OP_LW   = 32'd3;
    localparam logic [31:0] OP_SW   = 32'd4;
    localparam logic [31:0] OP_BEQ  = 32'd5;
    localparam logic [31:0] OP_ADDI = 32'd6;
    localparam logic [31:0] OP_ANDI = 32'd7;
    localparam logic [31:0] OP_J0   = 32'd8;
    localparam logic [31:0] OP_J1   = 32'd9;
    localparam logic [31:0] OP_J2   = 32'd10;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NONE = 3'd7;   // undefined opcode marker

    typedef enum logic [1:0] {
        STALL    = 2'd0,
        INC      = 2'd1,
        CONDLOAD = 2'd2
    } pc_ctrl_e;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic [2:0] alu_sel;
    } ctrl_t;

endpackage

// File: rtl/pipe_control_decode.sv
// ctrl_decode: purely combinational opcode decoder.
// Ports:
//   opcode  in   OPW  opcode from the IF/ID register
//   ctrl    out  ctrl_t datapath control bundle
// Opcodes outside the table give all controls 0 and ALU_NONE.
module ctrl_decode
    import pipe_control_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl
);

    logic [31:0] op_ext;
    assign op_ext = 32'(opcode);

    always_comb begin
        ctrl = '0;
        case (op_ext)
            OP_ADD:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_sel = ALU_ADD; end
            OP_SUB:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_sel = ALU_SUB; end
            OP_SLT:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_sel = ALU_SLT; end
            OP_LW:   begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
            OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.alu_sel = ALU_SUB; end
            OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_sel = ALU_ADD; end
            OP_ANDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_sel = ALU_AND; end
            OP_J0, OP_J1, OP_J2: ctrl.jump = 1'b1;
            default: ctrl.alu_sel = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// pipe_control: control unit for a datapath that runs either multicycle
// (Mode=0, CYCLES phases per instruction) or pipelined (Mode=1).
// Ports:
//   clock, reset (async, active-low)
//   Mode, OpCode, MemReady, Taken           mode select / decode / stage status
//   ID_Rs, ID_Rt, EX_Rd, EX_MemRead         load-use hazard inputs
//   PCControl (STALL/INC/CONDLOAD), IFIDWrite, Bubble, Flush, Freeze
//   RegWrite..MemtoReg, ALU_Select          datapath controls
//   Phase                                   multicycle phase (debug view of the FSM)
// Build option: define PIPE_CONTROL_HAZARD_EN to enable load-use stalls;
// without it the hazard inputs are ignored and software must insert nops.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int RW     = 3,
    parameter int CYCLES = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           Mode,
    input  logic [OPW-1:0] OpCode,
    input  logic           MemReady,
    input  logic           Taken,
    input  logic [RW-1:0]  ID_Rs,
    input  logic [RW-1:0]  ID_Rt,
    input  logic [RW-1:0]  EX_Rd,
    input  logic           EX_MemRead,
    output logic [1:0]     PCControl,
    output logic           IFIDWrite,
    output logic           Bubble,
    output logic           Flush,
    output logic           Freeze,
    output logic           RegWrite,
    output logic           RegDst,
    output logic           ALUSrc,
    output logic           Branch,
    output logic           Jump,
    output logic           MemWrite,
    output logic           MemRead,
    output logic           MemtoReg,
    output logic [2:0]     ALU_Select,
    output logic [2:0]     Phase
);

    localparam logic [2:0] LAST_PHASE = 3'(CYCLES - 1);

    ctrl_t      dec_ctrl;
    ctrl_t      ctrl_out;
    ctrl_t      ctrl_q;        // controls shown on the last non-frozen cycle
    pc_ctrl_e   pc_sel;
    logic       mode_q;        // ModeReg
    logic [2:0] phase_q;
    logic       mem_instr_q;   // instruction in flight is lw/sw: may wait for memory
    logic       hz_done_q;     // last advancing pipelined cycle was a load-use stall
    logic       hazard;
    logic       stall_now;
    logic       ifid_we, bubble, flush, freeze;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode (OpCode),
        .ctrl   (dec_ctrl)
    );

`ifdef PIPE_CONTROL_HAZARD_EN
    // hz_done_q limits the stall to one cycle per load even if the
    // hazard inputs stay asserted.
    assign hazard = EX_MemRead && (EX_Rd != '0) &&
                    ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt)) && !hz_done_q;
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{ID_Rs, ID_Rt, EX_Rd, EX_MemRead, hz_done_q};
    assign hazard = 1'b0;
`endif

    // A load-use stall only happens when nothing of higher priority wins.
    assign stall_now = mode_q && MemReady && !Taken && hazard;

    // Outputs follow the state and same-cycle stage status; reset forces
    // the safe values combinationally so they appear without a clock edge.
    always_comb begin
        pc_sel   = STALL;
        ifid_we  = 1'b0;
        bubble   = 1'b1;
        flush    = 1'b0;
        freeze   = 1'b0;
        ctrl_out = '0;
        if (!reset) begin
            // hold reset values
        end else if (!mode_q) begin
            if (phase_q == 3'd0) begin
                pc_sel  = INC;
                ifid_we = 1'b1;
            end else if (phase_q == 3'd1) begin
                ctrl_out = dec_ctrl;
                bubble   = 1'b0;
            end else if (phase_q == LAST_PHASE) begin
                pc_sel = (mem_instr_q && !MemReady) ? STALL : CONDLOAD;
            end
        end else begin
            pc_sel   = INC;
            ifid_we  = 1'b1;
            bubble   = 1'b0;
            ctrl_out = dec_ctrl;
            if (!MemReady) begin
                freeze   = 1'b1;
                pc_sel   = STALL;
                ifid_we  = 1'b0;
                ctrl_out = ctrl_q;
            end else if (Taken) begin
                pc_sel = CONDLOAD;
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (hazard) begin
                pc_sel  = STALL;
                ifid_we = 1'b0;
                bubble  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q     <= 3'd0;
            mode_q      <= 1'b0;
            mem_instr_q <= 1'b0;
            hz_done_q   <= 1'b0;
            ctrl_q      <= '0;
        end else if (!mode_q) begin
            hz_done_q <= 1'b0;
            ctrl_q    <= ctrl_out;
            if (phase_q == 3'd0) begin
                // Instruction boundary: a switch to pipelined parks Phase at 0.
                mode_q  <= Mode;
                phase_q <= Mode ? 3'd0 : 3'd1;
            end else if (phase_q == LAST_PHASE) begin
                if (!(mem_instr_q && !MemReady)) begin
                    phase_q     <= 3'd0;
                    mem_instr_q <= 1'b0;
                end
            end else begin
                if (phase_q == 3'd1) begin
                    mem_instr_q <= dec_ctrl.mem_read | dec_ctrl.mem_write;
                end
                phase_q <= phase_q + 3'd1;
            end
        end else begin
            phase_q <= 3'd0;
            if (MemReady) begin
                mode_q    <= Mode;
                hz_done_q <= stall_now;
                ctrl_q    <= ctrl_out;
            end
        end
    end

    assign PCControl  = pc_sel;
    assign IFIDWrite  = ifid_we;
    assign Bubble     = bubble;
    assign Flush      = flush;
    assign Freeze     = freeze;
    assign RegWrite   = ctrl_out.reg_write;
    assign RegDst     = ctrl_out.reg_dst;
    assign ALUSrc     = ctrl_out.alu_src;
    assign Branch     = ctrl_out.branch;
    assign Jump       = ctrl_out.jump;
    assign MemWrite   = ctrl_out.mem_write;
    assign MemRead    = ctrl_out.mem_read;
    assign MemtoReg   = ctrl_out.mem_to_reg;
    assign ALU_Select = ctrl_out.alu_sel;
    assign Phase      = phase_q;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: self-checking bench for pipe_control.
// Two instances share all inputs: dut_a with CYCLES=4, dut_b with CYCLES=8.
// Output vector layout: {PCControl, IFIDWrite, Bubble, Flush, Freeze,
// RegWrite, RegDst, ALUSrc, Branch, Jump, MemWrite, MemRead, MemtoReg,
// ALU_Select, Phase}.
module tb_pipe_control;

  localparam logic [19:0] RESET_VEC = 20'h10000;  // only Bubble=1
  localparam int CYC = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       Mode, MemReady, Taken, EX_MemRead;
  logic [3:0] OpCode;
  logic [2:0] ID_Rs, ID_Rt, EX_Rd;

  logic [1:0] a_pc, b_pc;
  logic a_ifid, a_bub, a_fl, a_fz, a_rw, a_rd, a_as, a_br, a_jp, a_mw, a_mr, a_m2r;
  logic b_ifid, b_bub, b_fl, b_fz, b_rw, b_rd, b_as, b_br, b_jp, b_mw, b_mr, b_m2r;
  logic [2:0] a_alu, a_ph, b_alu, b_ph;

  pipe_control #(.OPW(4), .RW(3), .CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .Mode(Mode), .OpCode(OpCode), .MemReady(MemReady),
    .Taken(Taken), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
    .PCControl(a_pc), .IFIDWrite(a_ifid), .Bubble(a_bub), .Flush(a_fl), .Freeze(a_fz),
    .RegWrite(a_rw), .RegDst(a_rd), .ALUSrc(a_as), .Branch(a_br), .Jump(a_jp),
    .MemWrite(a_mw), .MemRead(a_mr), .MemtoReg(a_m2r), .ALU_Select(a_alu), .Phase(a_ph)
  );

  pipe_control #(.OPW(4), .RW(3), .CYCLES(8)) dut_b (
    .clock(clock), .reset(reset), .Mode(Mode), .OpCode(OpCode), .MemReady(MemReady),
    .Taken(Taken), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
    .PCControl(b_pc), .IFIDWrite(b_ifid), .Bubble(b_bub), .Flush(b_fl), .Freeze(b_fz),
    .RegWrite(b_rw), .RegDst(b_rd), .ALUSrc(b_as), .Branch(b_br), .Jump(b_jp),
    .MemWrite(b_mw), .MemRead(b_mr), .MemtoReg(b_m2r), .ALU_Select(b_alu), .Phase(b_ph)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] got_a();
    return {a_pc, a_ifid, a_bub, a_fl, a_fz, a_rw, a_rd, a_as, a_br, a_jp, a_mw, a_mr, a_m2r, a_alu, a_ph};
  endfunction

  function automatic logic [19:0] got_b();
    return {b_pc, b_ifid, b_bub, b_fl, b_fz, b_rw, b_rd, b_as, b_br, b_jp, b_mw, b_mr, b_m2r, b_alu, b_ph};
  endfunction

  function automatic logic [19:0] mkv(input logic [1:0] pc, input logic ifid, input logic bub,
                                      input logic fl, input logic fz, input logic [7:0] cb,
                                      input logic [2:0] alu, input logic [2:0] ph);
    return {pc, ifid, bub, fl, fz, cb, alu, ph};
  endfunction

  // ---------------- reference model ----------------
  // Decode table straight from the opcode list: {8 control bits, ALU code}.
  logic [10:0] dec_tab[16];
  int          m_mode, m_phase;
  bit          m_wait_mem, m_stalled, e_stall;
  logic [10:0] m_last, e_ctrl;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_wait_mem = 0; m_stalled = 0; m_last = '0;
  endtask

  // Expected outputs for the current cycle; pushes onto exp_q.
  task automatic model_eval();
    logic [1:0] pc;
    logic ifid, bub, fl, fz, hz;
    pc = 2'd0; ifid = 0; bub = 1; fl = 0; fz = 0; e_ctrl = '0; e_stall = 0;
`ifdef PIPE_CONTROL_HAZARD_EN
    hz = EX_MemRead && (EX_Rd != 0) && (EX_Rd == ID_Rs || EX_Rd == ID_Rt);
`else
    hz = 0;
`endif
    if (m_mode == 0) begin
      if (m_phase == 0) begin pc = 2'd1; ifid = 1; end
      else if (m_phase == 1) begin e_ctrl = dec_tab[OpCode]; bub = 0; end
      else if (m_phase == CYC - 1) pc = (m_wait_mem && !MemReady) ? 2'd0 : 2'd2;
    end else begin
      pc = 2'd1; ifid = 1; bub = 0; e_ctrl = dec_tab[OpCode];
      if (!MemReady) begin pc = 2'd0; ifid = 0; fz = 1; e_ctrl = m_last; end
      else if (Taken) begin pc = 2'd2; fl = 1; bub = 1; end
      else if (hz && !m_stalled) begin pc = 2'd0; ifid = 0; bub = 1; e_stall = 1; end
    end
    exp_q.push_back({pc, ifid, bub, fl, fz, e_ctrl, 3'(m_phase)});
  endtask

  // Advance the model across one rising edge using this cycle's inputs.
  task automatic model_tick();
    if (m_mode == 0) begin
      m_last = e_ctrl;
      m_stalled = 0;
      if (m_phase == 0) begin
        m_mode = int'(Mode);
        if (!Mode) m_phase = 1;
      end else if (m_phase < CYC - 1) begin
        if (m_phase == 1) m_wait_mem = (OpCode == 4'd3) || (OpCode == 4'd4);
        m_phase++;
      end else if (!(m_wait_mem && !MemReady)) begin
        m_phase = 0;
      end
    end else if (MemReady) begin
      m_last = e_ctrl;
      m_stalled = e_stall;
      m_mode = int'(Mode);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    Mode = 0; OpCode = '0; MemReady = 1; Taken = 0;
    ID_Rs = '0; ID_Rt = '0; EX_Rd = '0; EX_MemRead = 0;
    #2;
    check("reset_vals_a", got_a(), RESET_VEC);
    check("reset_vals_b", got_b(), RESET_VEC);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        mem_ready;
    logic        taken;
    logic [19:0] exp;
  } vec_t;

  vec_t tab[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mr_seq[7];
    int pc_seq[7];
    int ph_seq[7];
    logic [19:0] e;

    for (int i = 0; i < 16; i++) dec_tab[i] = {8'h00, 3'd7};
    dec_tab[0]  = {8'b11000000, 3'd0};
    dec_tab[1]  = {8'b11000000, 3'd1};
    dec_tab[2]  = {8'b11000000, 3'd2};
    dec_tab[3]  = {8'b10100011, 3'd0};
    dec_tab[4]  = {8'b00100100, 3'd0};
    dec_tab[5]  = {8'b00010000, 3'd1};
    dec_tab[6]  = {8'b10100000, 3'd0};
    dec_tab[7]  = {8'b10100000, 3'd4};
    dec_tab[8]  = {8'b00001000, 3'd0};
    dec_tab[9]  = {8'b00001000, 3'd0};
    dec_tab[10] = {8'b00001000, 3'd0};

    // Pipelined vectors (no hazard inputs); two frozen cycles hold the
    // controls of the op 12 cycle before them.
    tab[0]  = '{4'd0,  1, 0, mkv(1, 1, 0, 0, 0, 8'b11000000, 3'd0, 0)};
    tab[1]  = '{4'd1,  1, 0, mkv(1, 1, 0, 0, 0, 8'b11000000, 3'd1, 0)};
    tab[2]  = '{4'd2,  1, 0, mkv(1, 1, 0, 0, 0, 8'b11000000, 3'd2, 0)};
    tab[3]  = '{4'd3,  1, 0, mkv(1, 1, 0, 0, 0, 8'b10100011, 3'd0, 0)};
    tab[4]  = '{4'd4,  1, 0, mkv(1, 1, 0, 0, 0, 8'b00100100, 3'd0, 0)};
    tab[5]  = '{4'd5,  1, 0, mkv(1, 1, 0, 0, 0, 8'b00010000, 3'd1, 0)};
    tab[6]  = '{4'd6,  1, 0, mkv(1, 1, 0, 0, 0, 8'b10100000, 3'd0, 0)};
    tab[7]  = '{4'd7,  1, 0, mkv(1, 1, 0, 0, 0, 8'b10100000, 3'd4, 0)};
    tab[8]  = '{4'd9,  1, 0, mkv(1, 1, 0, 0, 0, 8'b00001000, 3'd0, 0)};
    tab[9]  = '{4'd12, 1, 0, mkv(1, 1, 0, 0, 0, 8'b00000000, 3'd7, 0)};
    tab[10] = '{4'd6,  0, 0, mkv(0, 0, 0, 0, 1, 8'b00000000, 3'd7, 0)};
    tab[11] = '{4'd6,  0, 1, mkv(0, 0, 0, 0, 1, 8'b00000000, 3'd7, 0)};
    tab[12] = '{4'd6,  1, 1, mkv(2, 1, 1, 1, 0, 8'b10100000, 3'd0, 0)};
    tab[13] = '{4'd15, 1, 0, mkv(1, 1, 0, 0, 0, 8'b00000000, 3'd7, 0)};

    // Multicycle add: PCControl 1,0,0,2; RegWrite/RegDst only in phase 1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #2;
      check("mc_add_pc", 20'(a_pc), (i % 4 == 0) ? 20'd1 : (i % 4 == 3) ? 20'd2 : 20'd0);
      check("mc_add_rw_rd", 20'({a_rw, a_rd}), (i % 4 == 1) ? 20'd3 : 20'd0);
      check("mc_add_phase", 20'(a_ph), 20'(i % 4));
      if (i % 4 != 0) check("mc_add_ifid", 20'(a_ifid), 20'd0);
      tick();
    end

    // Multicycle lw with two cycles of memory wait at the last phase.
    do_reset();
    OpCode = 4'd3;
    mr_seq = '{1, 1, 1, 0, 0, 1, 1};
    pc_seq = '{1, 0, 0, 0, 0, 2, 1};
    ph_seq = '{0, 1, 2, 3, 3, 3, 0};
    for (int i = 0; i < 7; i++) begin
      MemReady = mr_seq[i][0];
      #2;
      check("mc_lw_pc", 20'(a_pc), 20'(pc_seq[i]));
      check("mc_lw_phase", 20'(a_ph), 20'(ph_seq[i]));
      tick();
    end

    // Pipelined table.
    do_reset();
    Mode = 1;
    #2;
    check("first_fetch", got_a(), mkv(1, 1, 1, 0, 0, 8'h00, 3'd0, 3'd0));
    tick();
    for (int i = 0; i < 14; i++) begin
      OpCode = tab[i].op; MemReady = tab[i].mem_ready; Taken = tab[i].taken;
      #2;
      check($sformatf("pipe_vec%0d", i), got_a(), tab[i].exp);
      tick();
    end

    // Load-use hazard held for two cycles: one stall only; EX_Rd=0 never stalls.
    OpCode = 4'd0; MemReady = 1; Taken = 0;
    EX_MemRead = 1; EX_Rd = 3'd2; ID_Rt = 3'd2; ID_Rs = 3'd5;
    #2;
`ifdef PIPE_CONTROL_HAZARD_EN
    check("hz_stall", got_a(), mkv(0, 0, 1, 0, 0, 8'b11000000, 3'd0, 0));
`else
    check("hz_stall", got_a(), mkv(1, 1, 0, 0, 0, 8'b11000000, 3'd0, 0));
`endif
    tick(); #2;
    check("hz_after", got_a(), mkv(1, 1, 0, 0, 0, 8'b11000000, 3'd0, 0));
    tick();
    EX_Rd = 3'd0; ID_Rt = 3'd0; ID_Rs = 3'd0;
    #2;
    check("hz_rd0", got_a(), mkv(1, 1, 0, 0, 0, 8'b11000000, 3'd0, 0));
    tick();

    // Taken beats hazard; MemReady=0 beats both.
    EX_Rd = 3'd2; ID_Rt = 3'd2; Taken = 1;
    #2;
    check("taken_over_hz", got_a(), mkv(2, 1, 1, 1, 0, 8'b11000000, 3'd0, 0));
    tick();
    MemReady = 0;
    #2;
    check("freeze_over_all", got_a(), mkv(0, 0, 0, 0, 1, 8'b11000000, 3'd0, 0));
    tick();

    // Asynchronous reset in the middle of phase 2.
    do_reset();
    tick(); tick();
    #2;
    check("pre_reset_phase", 20'(a_ph), 20'd2);
    reset = 0;
    #1;
    check("async_reset", got_a(), RESET_VEC);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    #2;
    check("after_release", got_a(), mkv(1, 1, 1, 0, 0, 8'h00, 3'd0, 3'd0));
    tick();

    // CYCLES=8 with an undefined opcode.
    do_reset();
    OpCode = 4'd15;
    for (int i = 0; i < 16; i++) begin
      #2;
      check("c8_phase", 20'(b_ph), 20'(i % 8));
      check("c8_pc", 20'(b_pc), (i % 8 == 0) ? 20'd1 : (i % 8 == 7) ? 20'd2 : 20'd0);
      check("c8_alu", 20'(b_alu), (i % 8 == 1) ? 20'd7 : 20'd0);
      tick();
    end

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) Mode = ~Mode;
      OpCode     = 4'($urandom_range(0, 15));
      MemReady   = ($urandom_range(0, 9) < 8);
      Taken      = ($urandom_range(0, 9) < 2);
      EX_MemRead = 1'($urandom_range(0, 1));
      EX_Rd      = 3'($urandom_range(0, 3));
      ID_Rs      = 3'($urandom_range(0, 3));
      ID_Rt      = 3'($urandom_range(0, 3));
      #2;
      model_eval();
      e = exp_q.pop_front();
      check("random_model", got_a(), e);
      model_tick();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
